// File: rtl/nano_loader_if.sv
// Signal bundle between the program source / NanoCPU side and nano_loader:
// byte stream, CPU memory port, physical memory port and status.
interface nano_loader_if;
  // Byte stream: a byte moves on a rising edge where rx_valid && rx_ready.
  // rx_ready comes from loader state only; the source may raise or drop
  // rx_valid at any time, and a byte offered while rx_ready=0 stays unconsumed.
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        cpu_rst;
  logic [7:0]  cpu_address;
  logic [15:0] cpu_dataW;
  logic        cpu_ce;
  logic        cpu_we;
  logic [15:0] cpu_dataR;
  logic [7:0]  mem_address;
  logic [15:0] mem_dataW;
  logic        mem_ce;
  logic        mem_we;
  logic [15:0] mem_dataR;
  logic        done;
  logic        error;
  logic [2:0]  state_dbg;

  modport master (
    output rx_data, rx_valid, reload, cpu_address, cpu_dataW, cpu_ce, cpu_we, mem_dataR,
    input  rx_ready, cpu_rst, cpu_dataR, mem_address, mem_dataW, mem_ce, mem_we,
           done, error, state_dbg
  );

  modport slave (
    input  rx_data, rx_valid, reload, cpu_address, cpu_dataW, cpu_ce, cpu_we, mem_dataR,
    output rx_ready, cpu_rst, cpu_dataR, mem_address, mem_dataW, mem_ce, mem_we,
           done, error, state_dbg
  );
endinterface

// File: rtl/nano_loader.sv
// Boot loader for the NanoCPU: receives length/words/XOR-checksum over a byte
// stream, writes words from address 0, then hands the memory port to the CPU.
module nano_loader (
  input  logic          ck,
  input  logic          rst,
  nano_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_WR   = 3'd3,
    S_CSUM = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] len_q;
  logic [7:0] acc_q;
  logic [7:0] wc_q;
  logic [7:0] hi_q;
  logic [7:0] lo_q;
  logic       xfer;
  logic       last_word;

  assign bus.rx_ready = (state == S_LEN) || (state == S_HI) ||
                        (state == S_LO)  || (state == S_CSUM);
  assign xfer         = bus.rx_valid && bus.rx_ready;
  // L=0 means 256 words; 8-bit L-1 wraps to 255 so the same compare covers it.
  assign last_word    = (wc_q == len_q - 8'd1);

  assign bus.cpu_rst   = (state != S_RUN);
  assign bus.done      = (state == S_RUN);
  assign bus.error     = (state == S_ERR);
  assign bus.cpu_dataR = bus.mem_dataR;
  assign bus.state_dbg = state;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= S_LEN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN:   if (xfer) state_nxt = S_HI;
      S_HI:    if (xfer) state_nxt = S_LO;
      S_LO:    if (xfer) state_nxt = S_WR;
      S_WR:    state_nxt = last_word ? S_CSUM : S_HI;
      S_CSUM:  if (xfer) state_nxt = (bus.rx_data == acc_q) ? S_RUN : S_ERR;
      S_RUN:   if (bus.reload) state_nxt = S_LEN;
      S_ERR:   if (bus.reload) state_nxt = S_LEN;
      default: state_nxt = S_LEN;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      len_q <= 8'd0;
      acc_q <= 8'd0;
      wc_q  <= 8'd0;
      hi_q  <= 8'd0;
      lo_q  <= 8'd0;
    end else begin
      case (state)
        S_LEN: begin
          if (xfer) begin
            len_q <= bus.rx_data;
            acc_q <= bus.rx_data;
            wc_q  <= 8'd0;
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_q  <= bus.rx_data;
            acc_q <= acc_q ^ bus.rx_data;
          end
        end
        S_LO: begin
          if (xfer) begin
            lo_q  <= bus.rx_data;
            acc_q <= acc_q ^ bus.rx_data;
          end
        end
        S_WR: begin
          if (!last_word) wc_q <= wc_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory port mux: loader owns it only in WR, the CPU only in RUN.
  always_comb begin
    bus.mem_address = 8'd0;
    bus.mem_dataW   = 16'd0;
    bus.mem_ce      = 1'b0;
    bus.mem_we      = 1'b0;
    case (state)
      S_WR: begin
        bus.mem_address = wc_q;
        bus.mem_dataW   = {hi_q, lo_q};
        bus.mem_ce      = 1'b1;
        bus.mem_we      = 1'b1;
      end
      S_RUN: begin
        bus.mem_address = bus.cpu_address;
        bus.mem_dataW   = bus.cpu_dataW;
        bus.mem_ce      = bus.cpu_ce;
        bus.mem_we      = bus.cpu_we;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/nano_loader.md
# nano_loader

Boot loader and memory-port arbiter between the program source and the NanoCPU's 256x16 memory. After reset it holds the CPU in reset and receives a program as a byte stream over a valid/ready handshake. It writes the program as 16-bit words from address 0 upward and checks a trailing XOR checksum. On a good checksum it releases the CPU and hands it the memory port; on a bad checksum it keeps the CPU in reset and flags an error.

## Interface
- No parameters (address width 8, word width 16 and byte width 8 are fixed by the NanoCPU memory interface).
- ck  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  incoming program byte
- rx_valid  in  1  rx_data holds a valid byte
- rx_ready  out  1  loader accepts a byte this cycle; transfer when rx_valid && rx_ready
- reload  in  1  single-cycle request to restart loading; honoured only in RUN or ERR
- cpu_rst  out  1  reset to the NanoCPU; 1 in every state except RUN
- cpu_address  in  8  CPU memory address
- cpu_dataW  in  16  CPU write data
- cpu_ce, cpu_we  in  1 each  CPU chip enable and write enable
- cpu_dataR  out  16  equal to mem_dataR at all times (combinational pass-through)
- mem_address  out  8  memory address
- mem_dataW  out  16  memory write data
- mem_ce, mem_we  out  1 each  memory chip enable and write enable
- mem_dataR  in  16  memory read data
- done  out  1  state == RUN
- error  out  1  state == ERR

## Operation
- Stream format: length byte L, then 2·N data bytes (high byte first, then low byte, per word), then checksum byte C.
  - N = L, except L = 0 means N = 256.
  - C must equal the XOR of L and all data bytes.
- FSM states: LEN, HI, LO, WR, CSUM, RUN, ERR. Reset state is LEN.
- LEN: rx_ready=1. On a transfer, store L, set acc=L, set word counter wc=0, go to HI.
- HI: rx_ready=1. On a transfer, latch the high byte, acc ^= byte, go to LO.
- LO: rx_ready=1. On a transfer, latch the low byte, acc ^= byte, go to WR.
- WR: rx_ready=0.
  - Drive mem_ce=1, mem_we=1, mem_address=wc, mem_dataW={hi,lo} for exactly one cycle.
  - If wc == L-1 (8-bit, so L=0 compares with 255), go to CSUM. Otherwise wc++ and go to HI.
- CSUM: rx_ready=1. On a transfer, go to RUN if byte == acc, else go to ERR.
- RUN: rx_ready=0.
  - mem_address/mem_dataW/mem_ce/mem_we = cpu_address/cpu_dataW/cpu_ce/cpu_we.
  - reload → LEN.
- ERR: rx_ready=0, memory outputs idle. reload → LEN.
- Memory outputs in all non-RUN states other than WR: mem_ce=0, mem_we=0, mem_address=0, mem_dataW=0.
- Without a transfer, every receiving state holds (rx_valid gaps are arbitrary in length).
- reload is ignored in LEN, HI, LO, WR and CSUM.
- rx_valid is ignored whenever rx_ready=0, and no byte is consumed.
- In RUN, CPU writes are not observed or checked by the loader.

## Timing
- Reset values:
  - state=LEN, so rx_ready=1, cpu_rst=1, done=0, error=0.
  - mem_ce=0, mem_we=0, mem_address=0, mem_dataW=0.
  - wc=0, acc=0, hi/lo latches=0.
- rx_ready, cpu_rst, done, error and the memory mux select are decoded from the state register only. None depends combinationally on rx_valid.
- Per-word cost: 3 cycles minimum (HI, LO, WR).
  - Full load at zero gaps = 1 + 3·N + 1 cycles.
  - cpu_rst falls on the first edge after the checksum transfer.
- reload in RUN/ERR: state=LEN and cpu_rst=1 on the next edge. Memory contents are not cleared.
- Asynchronous rst mid-load: immediately returns to LEN and drops any partial word.
  - Words already written stay in memory.
  - The next byte accepted is treated as a new L.
- wc is 8 bits. When N=256 it reaches 255, and the final compare handles the wrap with no overflow.

## Test plan
- L=2, words 0x1234, 0xABCD, C=0x02^0x12^0x34^0xAB^0xCD:
  - Writes mem[0]=0x1234 and mem[1]=0xABCD, each with one-cycle mem_we.
  - Ends with done=1, cpu_rst=0, and cpu_address passed through to mem_address.
- Same stream with C flipped in bit 0:
  - Ends with error=1, cpu_rst=1, rx_ready=0.
  - reload pulse → LEN with rx_ready=1 the next cycle.
- L=0 with 512 bytes of value i&0xFF and the correct C:
  - 256 writes, mem[255]={0xFE,0xFF}, wc wraps cleanly, and RUN is reached.
- Random 0–5-cycle rx_valid gaps on the L=2 stream:
  - Same memory result as the gap-free run.
  - No byte is consumed while rx_ready=0 in WR.
- Assert rst between HI and LO of word 1, then send a fresh L=1 stream with word 0x5555:
  - mem[0]=0x5555 and RUN is reached.
  - No stale high byte is used.
- reload pulsed during HI of an active load:
  - Ignored; the load completes normally.
